closest_hit_tracker: RTL and testbench

// Consumes the 1-cycle p_float greater_than comparator and keeps the nearest valid hit

---
 rtl/closest_hit_tracker.sv | 120 ++++++++++++
 tb/tb_closest_hit_tracker.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/closest_hit_tracker.sv
// closest_hit_tracker: keeps the nearest accepted hit over one ray's candidate packet.
// p_float (FP21) is sign-magnitude: {sign, 7-bit biased exponent, 13-bit mantissa}, exponent 0 = zero.
module greater_than (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [20:0] a_i,
   input  logic [20:0] b_i,
   output logic        gt_o
);
   logic gt_q, gt_d, az, bz;
   // Magnitudes compare as unsigned integers; negatives order in reverse, +0 equals -0.
   always_comb begin
      az = a_i[19:0] == 20'h0;
      bz = b_i[19:0] == 20'h0;
      gt_d = (az && bz) ? 1'b0 :
             (a_i[20] != b_i[20]) ? ~a_i[20] :
             a_i[20] ? (a_i[19:0] < b_i[19:0]) : (a_i[19:0] > b_i[19:0]);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) gt_q <= 1'b0;
      else        gt_q <= gt_d;
   assign gt_o = gt_q;
endmodule

module closest_hit_tracker #(
   parameter int          ID_W  = 16,
   parameter int          CNT_W = 8,
   parameter logic [20:0] T_MIN = 21'h0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [20:0]      in_t,
   input  logic [ID_W-1:0]  in_id,
   input  logic             in_hit,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [20:0]      out_t,
   output logic [ID_W-1:0]  out_id,
   output logic             out_hit,
   output logic [CNT_W-1:0] out_cnt
);
   typedef enum logic [1:0] {ACCEPT, UPDATE, OUTPUT} state_e;
   state_e            state_q;
   logic [20:0]       cand_t_q, best_t_q, best_t_d, out_t_q;
   logic [ID_W-1:0]   cand_id_q, best_id_q, best_id_d, out_id_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d, out_cnt_q;
   logic              cand_hit_q, cand_last_q, have_hit_q, have_hit_d, out_valid_q, out_hit_q;
   logic              gt_a, gt_b, take;

   // Both comparators sample in_t every cycle; the result used in UPDATE is from the handshake edge.
   greater_than u_gta (.clk(clk), .rst_n(rst_n), .a_i(best_t_q), .b_i(in_t),  .gt_o(gt_a));
   greater_than u_gtb (.clk(clk), .rst_n(rst_n), .a_i(in_t),     .b_i(T_MIN), .gt_o(gt_b));

   always_comb begin
      take       = cand_hit_q & gt_b & (~have_hit_q | gt_a);
      best_t_d   = take ? cand_t_q : best_t_q;
      best_id_d  = take ? cand_id_q : best_id_q;
      have_hit_d = have_hit_q | take;
      cnt_d      = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACCEPT;
         cand_t_q    <= '0;
         cand_id_q   <= '0;
         cand_hit_q  <= 1'b0;
         cand_last_q <= 1'b0;
         best_t_q    <= '0;
         best_id_q   <= '0;
         have_hit_q  <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_t_q     <= '0;
         out_id_q    <= '0;
         out_hit_q   <= 1'b0;
         out_cnt_q   <= '0;
      end else begin
         case (state_q)
            ACCEPT: if (in_valid) begin
               cand_t_q    <= in_t;
               cand_id_q   <= in_id;
               cand_hit_q  <= in_hit;
               cand_last_q <= in_last;
               state_q     <= UPDATE;
            end
            UPDATE: begin
               best_t_q   <= best_t_d;
               best_id_q  <= best_id_d;
               have_hit_q <= have_hit_d;
               cnt_q      <= cnt_d;
               state_q    <= cand_last_q ? OUTPUT : ACCEPT;
               if (cand_last_q) begin
                  out_valid_q <= 1'b1;
                  out_t_q     <= have_hit_d ? best_t_d : '0;
                  out_id_q    <= have_hit_d ? best_id_d : '0;
                  out_hit_q   <= have_hit_d;
                  out_cnt_q   <= cnt_d;
               end
            end
            default: if (out_ready) begin
               out_valid_q <= 1'b0;
               have_hit_q  <= 1'b0;
               cnt_q       <= '0;
               state_q     <= ACCEPT;
            end
         endcase
      end
   end

   assign in_ready  = state_q == ACCEPT;
   assign out_valid = out_valid_q;
   assign out_t     = out_t_q;
   assign out_id    = out_id_q;
   assign out_hit   = out_hit_q;
   assign out_cnt   = out_cnt_q;
endmodule

// File: tb/tb_closest_hit_tracker.sv
// tb_closest_hit_tracker: directed packets with hand-computed FP21 results; a second
// instance with CNT_W=2 shares the inputs to exercise counter saturation.
module tb_closest_hit_tracker;
   localparam logic [20:0] T0_0 = 21'h000000, T1_0 = 21'h07E000, T1_5 = 21'h07F000,
                           T2_0 = 21'h080000, T2_5 = 21'h080800, T3_0 = 21'h081000,
                           T4_0 = 21'h082000, T5_0 = 21'h082800, T6_0 = 21'h083000,
                           TM1_0 = 21'h17E000;
   logic clk = 0, rst_n = 0;
   logic in_valid = 0, in_hit = 0, in_last = 0, out_ready = 0;
   logic [20:0] in_t = '0;
   logic [15:0] in_id = '0;
   logic in_ready, out_valid, out_hit;
   logic [20:0] out_t;
   logic [15:0] out_id;
   logic [7:0]  out_cnt;
   logic s_in_ready, s_out_valid, s_out_hit;
   logic [20:0] s_out_t;
   logic [15:0] s_out_id;
   logic [1:0]  s_out_cnt;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   closest_hit_tracker dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_t(in_t),
      .in_id(in_id), .in_hit(in_hit), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_t(out_t), .out_id(out_id), .out_hit(out_hit), .out_cnt(out_cnt));

   closest_hit_tracker #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_t(in_t),
      .in_id(in_id), .in_hit(in_hit), .in_last(in_last), .out_valid(s_out_valid),
      .out_ready(out_ready), .out_t(s_out_t), .out_id(s_out_id), .out_hit(s_out_hit), .out_cnt(s_out_cnt));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [20:0] t, input logic [15:0] id, input logic hit, input logic last);
      in_valid = 1; in_t = t; in_id = id; in_hit = hit; in_last = last;
      for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
      chk("in_ready_wait", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 0; in_last = 0; in_hit = 0;
   endtask

   task automatic collect(input string tag, input logic [20:0] t, input logic [15:0] id,
                          input logic hit, input logic [7:0] cnt);
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_t"},     32'(out_t), 32'(t));
      chk({tag, "_id"},    32'(out_id), 32'(id));
      chk({tag, "_hit"},   32'(out_hit), 32'(hit));
      chk({tag, "_cnt"},   32'(out_cnt), 32'(cnt));
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_t"},     32'(out_t), 32'd0);
      chk({tag, "_id"},    32'(out_id), 32'd0);
      chk({tag, "_hit"},   32'(out_hit), 32'd0);
      chk({tag, "_cnt"},   32'(out_cnt), 32'd0);
      chk({tag, "_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst_n = 1;
      @(negedge clk);

      send(T4_0, 16'd1, 1, 0);
      send(T1_5, 16'd2, 1, 0);
      send(T2_5, 16'd3, 1, 1);
      chk("lat_upd_valid", 32'(out_valid), 32'd0);
      chk("lat_upd_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("lat_out_valid", 32'(out_valid), 32'd1);
      collect("min3", T1_5, 16'd2, 1, 8'd3);
      chk("post_take_ready", 32'(in_ready), 32'd1);

      // Mid-packet asynchronous reset clears the stale result and the partial packet.
      send(T2_0, 16'd20, 1, 0);
      send(T1_0, 16'd21, 1, 0);
      #2 rst_n = 0;
      #1 chk_zero("midrst");
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      send(T3_0, 16'd7, 1, 1);
      collect("after_rst", T3_0, 16'd7, 1, 8'd1);

      send(T2_0,  16'd5, 1, 0);
      send(T2_0,  16'd6, 1, 0);
      send(TM1_0, 16'd7, 1, 0);
      send(T0_0,  16'd8, 1, 1);
      collect("ties", T2_0, 16'd5, 1, 8'd4);

      send(T1_0, 16'd30, 0, 0);
      send(T2_0, 16'd31, 0, 0);
      send(T1_5, 16'd32, 0, 1);
      collect("allmiss", T0_0, 16'd0, 0, 8'd3);

      send(T6_0, 16'd10, 1, 0);
      send(T5_0, 16'd11, 1, 0);
      send(T4_0, 16'd12, 1, 0);
      send(T3_0, 16'd13, 1, 0);
      send(T2_5, 16'd14, 1, 0);
      send(T1_5, 16'd15, 1, 1);
      for (int i = 0; i < 20 && !s_out_valid; i++) @(negedge clk);
      chk("sat_cnt", 32'(s_out_cnt), 32'd3);
      chk("sat_id", 32'(s_out_id), 32'd15);
      collect("six", T1_5, 16'd15, 1, 8'd6);

      send(T1_0, 16'd9, 1, 1);
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_t",     32'(out_t), 32'(T1_0));
         chk("bp_id",    32'(out_id), 32'd9);
         chk("bp_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      chk("bp_release_ready", 32'(in_ready), 32'd1);
      chk("bp_release_valid", 32'(out_valid), 32'd0);

      send(T2_5, 16'd40, 1, 1);
      collect("single", T2_5, 16'd40, 1, 8'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
